// File: rtl/letc_core_alu_issue.sv
// LETC ALU issue stage: decodes RV32I OP/OP-IMM/LUI/AUIPC into an ALU operation plus two
// operands, and presents the result through a registered valid/ready stage with a skid buffer.

package letc_pkg;
  typedef logic [31:0] word_t;
endpackage

package letc_core_pkg;
  typedef enum logic [3:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_SLL,
    ALU_OP_SLT,
    ALU_OP_SLTU,
    ALU_OP_XOR,
    ALU_OP_SRL,
    ALU_OP_SRA,
    ALU_OP_OR,
    ALU_OP_AND
  } alu_op_e;
endpackage

module letc_core_alu_issue
  import letc_pkg::*;
  import letc_core_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  word_t           i_instr,
  input  word_t           i_pc,
  input  word_t           i_rs1_data,
  input  word_t           i_rs2_data,
  output logic            o_valid,
  input  logic            i_ready,
  output word_t [1:0]     o_alu_operands,
  output alu_op_e         o_alu_operation,
  output logic [4:0]      o_rd_idx,
  output logic            o_illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    word_t [1:0] operands;
    alu_op_e     operation;
    logic [4:0]  rd_idx;
    logic        illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  word_t      imm_i;
  word_t      imm_u;
  word_t      shamt;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_u  = {i_instr[31:12], 12'b0};
  assign shamt  = {27'b0, i_instr[24:20]};

  entry_t  dec;
  logic    legal;
  alu_op_e op;

  // Combinational decode of the offered instruction; illegal encodings collapse to ADD 0,0.
  always_comb begin
    legal = 1'b1;
    op    = ALU_OP_ADD;
    dec   = '0;
    dec.rd_idx = i_instr[11:7];
    unique case (opcode)
      OpcOp: begin
        dec.operands = {i_rs2_data, i_rs1_data};
        if (funct7 == F7Base) begin
          unique case (funct3)
            3'b000:  op = ALU_OP_ADD;
            3'b001:  op = ALU_OP_SLL;
            3'b010:  op = ALU_OP_SLT;
            3'b011:  op = ALU_OP_SLTU;
            3'b100:  op = ALU_OP_XOR;
            3'b101:  op = ALU_OP_SRL;
            3'b110:  op = ALU_OP_OR;
            default: op = ALU_OP_AND;
          endcase
        end else if (funct7 == F7Alt && funct3 == 3'b000) begin
          op = ALU_OP_SUB;
        end else if (funct7 == F7Alt && funct3 == 3'b101) begin
          op = ALU_OP_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OpcOpImm: begin
        dec.operands = {imm_i, i_rs1_data};
        unique case (funct3)
          3'b000: op = ALU_OP_ADD;
          3'b010: op = ALU_OP_SLT;
          3'b011: op = ALU_OP_SLTU;
          3'b100: op = ALU_OP_XOR;
          3'b110: op = ALU_OP_OR;
          3'b111: op = ALU_OP_AND;
          3'b001: begin
            dec.operands = {shamt, i_rs1_data};
            op    = ALU_OP_SLL;
            legal = (funct7 == F7Base);
          end
          default: begin
            dec.operands = {shamt, i_rs1_data};
            if (funct7 == F7Base) begin
              op = ALU_OP_SRL;
            end else if (funct7 == F7Alt) begin
              op = ALU_OP_SRA;
            end else begin
              legal = 1'b0;
            end
          end
        endcase
      end
      OpcLui:   dec.operands = {imm_u, 32'b0};
      OpcAuipc: dec.operands = {imm_u, i_pc};
      default:  legal = 1'b0;
    endcase
    dec.operation = op;
    if (!legal) begin
      dec.operands  = '0;
      dec.operation = ALU_OP_ADD;
      dec.illegal   = 1'b1;
    end
  end

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_xfer;
  logic   load_out;

  // Upstream may only push while the skid slot is free.
  assign in_xfer  = i_valid & ~skid_valid_q;
  // OUT can take new content when it is empty or being consumed this cycle.
  assign load_out = ~out_valid_q | i_ready;

  // Next-state for the two-entry output stage; the skid always drains into OUT first.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (i_flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (i_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (load_out) begin
      out_valid_d = in_xfer;
      if (in_xfer) begin
        out_d = dec;
      end
    end else if (in_xfer) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; reset clears data so outputs show ADD 0,0 with rd 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign o_ready         = ~skid_valid_q;
  assign o_valid         = out_valid_q;
  assign o_alu_operands  = out_q.operands;
  assign o_alu_operation = out_q.operation;
  assign o_rd_idx        = out_q.rd_idx;
  assign o_illegal       = out_q.illegal;

endmodule

// File: tb/tb_letc_core_alu_issue.sv
// Bench for letc_core_alu_issue: queue-based reference model checked every cycle, plus
// directed vectors with literal expectations.
module tb_letc_core_alu_issue;
  import letc_pkg::*;
  import letc_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  word_t       instr = '0;
  word_t       pc = '0;
  word_t       rs1 = '0;
  word_t       rs2 = '0;
  logic        dut_ready;
  logic        dut_valid;
  word_t [1:0] ops;
  alu_op_e     op;
  logic [4:0]  rd;
  logic        ill;

  int pass_cnt = 0;
  int total = 0;

  typedef struct {
    word_t      op0;
    word_t      op1;
    alu_op_e    op;
    logic [4:0] rd;
    logic       ill;
  } exp_t;

  exp_t q[$];
  bit   m_rdy;

  letc_core_alu_issue dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_flush         (flush),
    .i_valid         (valid),
    .o_ready         (dut_ready),
    .i_instr         (instr),
    .i_pc            (pc),
    .i_rs1_data      (rs1),
    .i_rs2_data      (rs2),
    .o_valid         (dut_valid),
    .i_ready         (ready),
    .o_alu_operands  (ops),
    .o_alu_operation (op),
    .o_rd_idx        (rd),
    .o_illegal       (ill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Architectural meaning of each supported encoding, by opcode class.
  function automatic exp_t ref_decode(input word_t i, input word_t p, input word_t a,
                                      input word_t b);
    exp_t       e;
    alu_op_e    reg_ops[8];
    alu_op_e    imm_ops[8];
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    reg_ops = '{ALU_OP_ADD, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
                ALU_OP_XOR, ALU_OP_SRL, ALU_OP_OR, ALU_OP_AND};
    imm_ops = reg_ops;
    f3 = i[14:12];
    f7 = i[31:25];
    ok = 1;
    e = '{op0: 0, op1: 0, op: ALU_OP_ADD, rd: i[11:7], ill: 0};
    case (i[6:0])
      7'h33: begin
        e.op0 = a;
        e.op1 = b;
        if (f7 == 7'h00) e.op = reg_ops[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = ALU_OP_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_OP_SRA;
        else ok = 0;
      end
      7'h13: begin
        e.op0 = a;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.op1 = word_t'(i[24:20]);
          if (f7 == 7'h00) e.op = imm_ops[f3];
          else if (f7 == 7'h20 && f3 == 3'd5) e.op = ALU_OP_SRA;
          else ok = 0;
        end else begin
          e.op1 = word_t'($signed(i[31:20]));
          e.op  = imm_ops[f3];
        end
      end
      7'h37: e.op1 = i & 32'hFFFF_F000;
      7'h17: begin
        e.op0 = p;
        e.op1 = i & 32'hFFFF_F000;
      end
      default: ok = 0;
    endcase
    if (!ok) e = '{op0: 0, op1: 0, op: ALU_OP_ADD, rd: i[11:7], ill: 1};
    return e;
  endfunction

  // Reference occupancy: a FIFO of at most two decoded entries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      m_rdy = q.size() < 2;
      if (q.size() > 0 && ready) void'(q.pop_front());
      if (valid && m_rdy) q.push_back(ref_decode(instr, pc, rs1, rs2));
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("o_ready", 32'(dut_ready), 32'(q.size() < 2));
      check("o_valid", 32'(dut_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        check("operand0", ops[0], q[0].op0);
        check("operand1", ops[1], q[0].op1);
        check("operation", 32'(op), 32'(q[0].op));
        check("rd_idx", 32'(rd), 32'(q[0].rd));
        check("illegal", 32'(ill), 32'(q[0].ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input word_t i, input word_t p, input word_t a, input word_t b);
    valid = 1'b1;
    instr = i;
    pc    = p;
    rs1   = a;
    rs2   = b;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, 32'(dut_valid), 32'd0);
    check({tag, "_ready"}, 32'(dut_ready), 32'd1);
    check({tag, "_op0"}, ops[0], 32'd0);
    check({tag, "_op1"}, ops[1], 32'd0);
    check({tag, "_op"}, 32'(op), 32'(ALU_OP_ADD));
    check({tag, "_rd"}, 32'(rd), 32'd0);
    check({tag, "_ill"}, 32'(ill), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst");
    #4 rst_n = 1'b1;

    // Decode vectors with the consumer always ready.
    ready = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    step();
    check("add_valid", 32'(dut_valid), 32'd1);
    check("add_op0", ops[0], 32'd5);
    check("add_op1", ops[1], 32'd7);
    check("add_op", 32'(op), 32'(ALU_OP_ADD));
    check("add_rd", 32'(rd), 32'd3);
    check("add_ill", 32'(ill), 32'd0);
    drive(32'h402081B3, 32'h0, 32'd5, 32'd7);
    step();
    check("sub_op", 32'(op), 32'(ALU_OP_SUB));
    drive(32'h40435293, 32'h0, 32'h8000_0000, 32'h0);
    step();
    check("srai_op0", ops[0], 32'h8000_0000);
    check("srai_op1", ops[1], 32'd4);
    check("srai_op", 32'(op), 32'(ALU_OP_SRA));
    check("srai_rd", 32'(rd), 32'd5);
    drive(32'h40431293, 32'h0, 32'h1234_5678, 32'h0);
    step();
    check("slli_bad_ill", 32'(ill), 32'd1);
    check("slli_bad_op", 32'(op), 32'(ALU_OP_ADD));
    check("slli_bad_op0", ops[0], 32'd0);
    check("slli_bad_op1", ops[1], 32'd0);
    drive(32'hABCDE0B7, 32'h0, 32'hFFFF_FFFF, 32'h0);
    step();
    check("lui_op0", ops[0], 32'd0);
    check("lui_op1", ops[1], 32'hABCD_E000);
    check("lui_op", 32'(op), 32'(ALU_OP_ADD));
    drive(32'h00001097, 32'h100, 32'h0, 32'h0);
    step();
    check("auipc_op0", ops[0], 32'h100);
    check("auipc_op1", ops[1], 32'h1000);
    // Back-to-back stream: ORI -1, SLTU, JAL (illegal), OP f7=0100000 f3=001 (illegal).
    drive(32'hFFF0E213, 32'h0, 32'h0F0F_0000, 32'h0);
    step();
    check("ori_op1", ops[1], 32'hFFFF_FFFF);
    drive(32'h0020B333, 32'h0, 32'd9, 32'd3);
    step();
    drive(32'h0000006F, 32'h40, 32'd1, 32'd2);
    step();
    check("jal_ill", 32'(ill), 32'd1);
    drive(32'h40209233, 32'h0, 32'd1, 32'd2);
    step();
    valid = 1'b0;
    step();

    // Backpressure: A, B, C with the consumer stalled after A.
    ready = 1'b0;
    drive(32'h00100093, 32'h0, 32'h0, 32'h0);
    step();
    check("bp_a_rd", 32'(rd), 32'd1);
    drive(32'h00200113, 32'h0, 32'h0, 32'h0);
    step();
    check("bp_full_ready", 32'(dut_ready), 32'd0);
    drive(32'h00300193, 32'h0, 32'h0, 32'h0);
    step();
    check("bp_hold_rd", 32'(rd), 32'd1);
    check("bp_hold_ready", 32'(dut_ready), 32'd0);
    ready = 1'b1;
    step();
    check("bp_b_rd", 32'(rd), 32'd2);
    step();
    check("bp_c_rd", 32'(rd), 32'd3);
    valid = 1'b0;
    step();
    check("bp_empty", 32'(dut_valid), 32'd0);

    // Flush while full with a new instruction offered.
    ready = 1'b0;
    drive(32'h00400213, 32'h0, 32'h0, 32'h0);
    step();
    drive(32'h00500293, 32'h0, 32'h0, 32'h0);
    step();
    drive(32'h00600313, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    check("flush_valid", 32'(dut_valid), 32'd0);
    check("flush_ready", 32'(dut_ready), 32'd1);
    flush = 1'b0;
    valid = 1'b0;
    ready = 1'b1;
    step();
    check("flush_dropped", 32'(dut_valid), 32'd0);

    // Asynchronous reset between edges while full.
    ready = 1'b0;
    drive(32'h00100093, 32'h0, 32'h0, 32'h0);
    step();
    drive(32'h00200113, 32'h0, 32'h0, 32'h0);
    step();
    valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    #2 rst_n = 1'b1;
    ready = 1'b1;
    drive(32'h00700393, 32'h0, 32'h0, 32'h0);
    step();
    check("post_rst_valid", 32'(dut_valid), 32'd1);
    check("post_rst_rd", 32'(rd), 32'd7);
    check("post_rst_op1", ops[1], 32'd7);
    valid = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/letc_core_alu_issue.md
# letc_core_alu_issue

Decode-side producer for the LETC single-cycle ALU. It accepts one RV32I instruction per cycle with its PC and register-file read data. It decodes OP, OP-IMM, LUI and AUIPC into an `alu_op_e` operation plus two `word_t` operands. Results are presented through a registered valid/ready output stage with a one-entry skid buffer, so the execute stage can apply backpressure without losing throughput.

## Interface
- No parameters; widths come from `letc_pkg::word_t` (32 bits) and `letc_core_pkg::alu_op_e`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_flush`  in  1  synchronous; discards every held entry.
- `i_valid`  in  1  upstream instruction valid.
- `o_ready`  out  1  upstream may transfer this cycle.
- `i_instr`  in  32  RV32I instruction word.
- `i_pc`  in  32  PC of `i_instr`.
- `i_rs1_data`  in  32  rs1 value.
- `i_rs2_data`  in  32  rs2 value.
- `o_valid`  out  1  output entry valid.
- `i_ready`  in  1  execute stage accepts the output entry.
- `o_alu_operands`  out  2x32  `[0]` OP `[1]`; drives the ALU operand inputs.
- `o_alu_operation`  out  `alu_op_e`  ALU operation.
- `o_rd_idx`  out  5  destination register, taken from `instr[11:7]`.
- `o_illegal`  out  1  instruction is not a supported ALU instruction.

## Operation
- Decode is combinational on the input. Its result is captured only on an input transfer, which happens when `i_valid & o_ready`.
- OP (opcode 0110011), operands `{rs1_data, rs2_data}`:
  - funct7 = 0000000: funct3 000/001/010/011/100/101/110/111 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 = 0100000: funct3 000 maps to SUB, funct3 101 maps to SRA.
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (opcode 0010011), operand0 = `rs1_data`:
  - funct3 000/010/011/100/110/111 maps to ADD/SLT/SLTU/XOR/OR/AND. Operand1 is `sext(instr[31:20])`.
  - funct3 001 requires funct7 = 0000000 and maps to SLL.
  - funct3 101 with funct7 = 0000000 maps to SRL; with funct7 = 0100000 it maps to SRA.
  - For all three shifts, operand1 is `{27'b0, instr[24:20]}`.
  - Any other funct7 on a shift is illegal.
- LUI (opcode 0110111): operands `{0, {instr[31:12],12'b0}}`, operation ADD.
- AUIPC (opcode 0010111): operands `{pc, {instr[31:12],12'b0}}`, operation ADD.
- Any other opcode is illegal.
- Illegal handling: operands 0, operation ADD, `o_illegal=1`. The entry is still transferred; a trap is not this block's job.
- Storage consists of an output register (OUT) and a skid register (SKID), each with its own valid bit.
  - `o_valid` = OUT.valid.
  - `o_ready` = !SKID.valid, registered.
- Occupancy states and transitions:
  - EMPTY (neither valid). An input transfer moves it to ONE.
  - ONE (OUT only):
    - input transfer with `i_ready`: OUT is replaced; state stays ONE.
    - input transfer without `i_ready`: the input goes to SKID; state becomes FULL.
    - `i_ready` with no input: state becomes EMPTY.
  - FULL (OUT and SKID), with `o_ready=0`:
    - `i_ready`: SKID moves to OUT and SKID clears; state becomes ONE.
    - no `i_ready`: state holds.
- Ordering is strictly FIFO, with no reordering or duplication.
- Flush has priority over every other event. Both valid bits clear on the next edge, any input offered in the flush cycle is dropped, and `o_ready=1` the next cycle.
- An output transfer completing in the flush cycle still counts as consumed.
- Data registers are not cleared by flush; only valid bits are.

## Timing
- Reset values: `o_valid=0`, `o_ready=1`, `o_alu_operands={0,0}`, `o_alu_operation=ALU_OP_ADD`, `o_rd_idx=0`, `o_illegal=0`; SKID cleared.
- Latency: an input transferred at edge N is on the outputs with `o_valid=1` in the cycle after edge N.
- Throughput: one instruction per cycle while `i_ready` is held high.
- Once `o_valid=1` and `i_ready=0`, all output fields are stable until the transfer.
- `o_ready` depends only on registered state, with no combinational path from `i_ready` or `i_valid`.
- Asynchronous reset asserted mid-operation immediately clears both entries and forces the reset values. After deassertion the first input transfer is possible at the next edge.

## Test plan
- ADD x3,x1,x2 (0x002081B3) with rs1=5, rs2=7, `i_ready=1` → next cycle operands {5,7}, ADD, rd=3, illegal=0. SUB (0x402081B3) → SUB.
- SRAI x5,x6,4 (0x40435293) with rs1=0x80000000 → operands {0x80000000, 4}, SRA, rd=5. SLLI with funct7=0100000 → illegal=1, ADD, operands {0,0}.
- LUI x1,0xABCDE (0xABCDE0B7) → {0, 0xABCDE000}, ADD. AUIPC x1,1 at pc=0x100 (0x00001097) → {0x100, 0x1000}, ADD.
- Backpressure: stream A,B,C with `i_ready=0` after A → A held and B in SKID, `o_ready=0` next cycle, C not accepted. Raise `i_ready` → outputs A, B, C in order, with no loss or duplicates.
- Flush while FULL with `i_valid=1` → next cycle `o_valid=0`, `o_ready=1`, and the offered instruction never appears.
- Assert `i_rst_n=0` mid-stream, asynchronously between edges → outputs go to the reset values immediately. After release, the first new instruction emerges with 1-cycle latency.
